sns_multiplier: RTL and testbench
=================================

# sns_multiplier

Sequential shift-and-add fractional multiplier that scales an 8-bit pixel/operand by an 8-bit Q1.7 fraction. The fraction is in the format `SnS_divider` produces as `frac_val`, so 128 represents 1.0. It is the inverse stage of the shift-and-subtract divider in the interpolation datapath: the divider turns a ratio into a fraction, and this block applies that fraction as a weight. The block runs MSB-first, one fraction bit per cycle, with its own internal 3-bit cycle counter and a start/busy/done handshake.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is ready (IDLE or DONE).
- frac_val  input  8  Q1.7 weight; value = frac_val/128, range 0 to 255/128.
- multiplicand  input  8  unsigned operand (pixel value).
- busy  output  1  high while in the RUN state.
- done  output  1  one-cycle pulse; product is valid and newly updated.
- product  output  8  round(multiplicand*frac_val/128), saturated to 255; held between operations.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - RUN: 8 accumulate cycles.
  - DONE: 1 cycle, done=1.
- Transitions:
  - IDLE→RUN when start=1.
  - RUN→DONE when cycle_cnt==7.
  - DONE→RUN when start=1; otherwise DONE→IDLE.
- On acceptance, capture frac_val into f_reg[7:0] and multiplicand into m_reg[7:0]. Also clear acc[15:0]=0 and cycle_cnt=0.
- RUN step k (cycle_cnt=k, k=0..7):
  - acc ← (acc<<1) + (f_reg[7-k] ? m_reg : 0).
  - cycle_cnt ← k+1, wrapping to 0 after 7.
- After 8 steps, acc = m_reg*f_reg (exact, at most 65025, fits 16 bits).
- On the RUN→DONE edge:
  - r = (acc + 64) >> 7, in 10 bits: round half up.
  - product ← (r > 255) ? 255 : r[7:0].
- start during RUN is ignored. Input changes during RUN do not affect the operation in progress, because operands are latched.
- product changes only on the RUN→DONE edge or on reset.

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0, acc=0, cycle_cnt=0. Reset overrides start and any state, including mid-RUN. The aborted operation produces no done pulse.
- Let E0 be the edge where start is accepted. Then:
  - busy=1 after E0 through E8.
  - Accumulate steps occur at edges E1..E8.
  - The product register loads at E8.
  - done=1 for the cycle after E8 (E8 to E9).
- Latency: 8 cycles from the accepting edge to product valid, with done visible in that cycle. Throughput: one result per 9 cycles.
- Back-to-back: if start=1 while done=1, the next operation is accepted at E9. busy rises again after E9, and done drops.
- busy and done are never high simultaneously. Both are registered outputs, with no combinational path from inputs.
- Saturation occurs only when frac_val > 128. For frac_val ≤ 128, the result never exceeds multiplicand.

## Test plan
- Reset, then start with frac_val=128 and multiplicand=200 → done exactly 9 edges after start is accepted; product=200; busy high for 8 cycles.
- frac_val=64, multiplicand=201 → product=101, from (12864+64)>>7, which checks rounding. Also frac_val=0, multiplicand=255 → product=0.
- frac_val=255, multiplicand=255 → product=255 (saturated, raw value 508). frac_val=192, multiplicand=100 → product=150.
- Chained check against the divider: for j=0..21, feed the divider's frac_val for j/21 with multiplicand=21 → product=j ±1.
- start held high continuously with new operands each operation → results back-to-back every 9 cycles. Pulses of start mid-RUN are ignored, and input changes mid-RUN do not alter the result.
- Assert rst at RUN step 4 → the next cycle shows busy=0, done=0, product=0. No done follows. A fresh start then completes normally.

Source files
------------

// File: rtl/sns_multiplier_if.sv
// Handshake/operand bundle for the shift-and-add fractional multiplier.
// The requester drives start and the operands; the multiplier returns busy,
// done and the saturated product.
interface sns_multiplier_if;
  logic       start;
  logic [7:0] frac_val;
  logic [7:0] multiplicand;
  logic       busy;
  logic       done;
  logic [7:0] product;

  modport master (
    output start,
    output frac_val,
    output multiplicand,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  frac_val,
    input  multiplicand,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/sns_multiplier.sv
// Sequential MSB-first shift-and-add multiplier that applies a Q1.7 weight
// (128 == 1.0) to an 8-bit operand. One weight bit is consumed per cycle over
// eight RUN cycles. The exact 16-bit product is then rounded half-up by 2^7
// and saturated to 8 bits.
module sns_multiplier (
  input logic          clk,
  input logic          rst,
  sns_multiplier_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_f;
  logic [7:0]  r_m;
  logic [15:0] r_acc;
  logic [2:0]  r_cnt;
  logic [7:0]  r_product;
  logic        r_busy;
  logic        r_done;

  logic        w_accept;
  logic        w_last;
  logic [15:0] w_addend;
  logic [15:0] w_acc_next;
  logic [15:0] w_sum;
  logic [9:0]  w_round;
  logic [7:0]  w_sat;

  // Next-state logic: a request is honoured only from IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_RUN;
        else           w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (r_cnt == 3'd7) w_state_next = S_DONE;
        else               w_state_next = S_RUN;
      end
      S_DONE: begin
        if (bus.start) w_state_next = S_RUN;
        else           w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control strobes and the accumulate/round/saturate arithmetic.
  // The final step's accumulator value is rounded directly so that the
  // product register can load on the same edge as the last accumulate.
  always_comb begin
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_addend   = 16'd0;
    w_acc_next = 16'd0;
    w_sum      = 16'd0;
    w_round    = 10'd0;
    w_sat      = 8'd0;

    if ((r_state == S_IDLE) || (r_state == S_DONE)) w_accept = bus.start;
    else                                            w_accept = 1'b0;

    if ((r_state == S_RUN) && (r_cnt == 3'd7)) w_last = 1'b1;
    else                                       w_last = 1'b0;

    if (r_f[3'd7 - r_cnt]) w_addend = {8'd0, r_m};
    else                   w_addend = 16'd0;

    w_acc_next = {r_acc[14:0], 1'b0} + w_addend;
    // At most 65025 + 64, so the 16-bit sum cannot overflow.
    w_sum      = w_acc_next + 16'd64;
    w_round    = {1'b0, w_sum[15:7]};

    if (w_round > 10'd255) w_sat = 8'd255;
    else                   w_sat = w_round[7:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Registered status outputs, derived from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
    end
  end

  // Datapath: latch operands on acceptance, then shift-and-add once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f       <= 8'd0;
      r_m       <= 8'd0;
      r_acc     <= 16'd0;
      r_cnt     <= 3'd0;
      r_product <= 8'd0;
    end else if (w_accept) begin
      r_f   <= bus.frac_val;
      r_m   <= bus.multiplicand;
      r_acc <= 16'd0;
      r_cnt <= 3'd0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + 3'd1;
      if (w_last) r_product <= w_sat;
      else        r_product <= r_product;
    end else begin
      r_acc     <= r_acc;
      r_cnt     <= r_cnt;
      r_product <= r_product;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_sns_multiplier.sv
// Self-checking bench for sns_multiplier: table-driven vectors, a scoreboard
// queue popped on every done pulse, and hand-written multi-cycle sequences
// (back-to-back, mid-run disturbance, reset abort).
module tb_sns_multiplier;

  logic clk;
  logic rst;
  sns_multiplier_if bus ();

  sns_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [0:10];
  logic [7:0] sb [$];
  int         errors = 0;
  int         checks = 0;
  bit         gap_check = 1'b0;
  longint     last_done_t = 0;

  function automatic logic [7:0] model(input logic [7:0] f, input logic [7:0] m);
    int p;
    p = (int'(f) * int'(m) + 64) / 128;
    if (p > 255) return 8'd255;
    else         return p[7:0];
  endfunction

  // Scoreboard / protocol monitor, sampling on the falling edge.
  always @(negedge clk) begin
    checks++;
    if (bus.busy && bus.done) begin
      errors++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", bus.busy, bus.done);
    end
    if (bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: done=1 with no outstanding operation, product=%0d", bus.product);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (bus.product !== e) begin
          errors++;
          $display("FAIL product: got %0d required %0d", bus.product, e);
        end
      end
      if (gap_check && last_done_t != 0) begin
        checks++;
        if (($time - last_done_t) != 90) begin
          errors++;
          $display("FAIL b2b_gap: got %0d required 90", $time - last_done_t);
        end
      end
      last_done_t = $time;
    end
  end

  // One operation: start at a ready point, optionally disturb inputs mid-run,
  // then check latency and busy length. Product is checked by the monitor.
  task automatic run_op(input logic [7:0] f, input logic [7:0] m, input bit mess);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.frac_val     = f;
    bus.multiplicand = m;
    bus.start        = 1'b1;
    sb.push_back(model(f, m));
    @(posedge clk);
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (mess && n < 8) begin
        bus.start        = 1'($urandom_range(0, 1));
        bus.frac_val     = 8'($urandom);
        bus.multiplicand = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 9) begin
      errors++;
      $display("FAIL latency: done after %0d negedges (seen=%0b) required 9", n, seen);
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL busy_len: got %0d required 8", busy_cnt);
    end
  endtask

  initial begin
    vecs[0]  = '{8'd128, 8'd200, 8'd200};
    vecs[1]  = '{8'd64,  8'd201, 8'd101};
    vecs[2]  = '{8'd0,   8'd255, 8'd0};
    vecs[3]  = '{8'd255, 8'd255, 8'd255};
    vecs[4]  = '{8'd192, 8'd100, 8'd150};
    vecs[5]  = '{8'd1,   8'd64,  8'd1};
    vecs[6]  = '{8'd1,   8'd63,  8'd0};
    vecs[7]  = '{8'd129, 8'd255, 8'd255};
    vecs[8]  = '{8'd128, 8'd255, 8'd255};
    vecs[9]  = '{8'd127, 8'd255, 8'd253};
    vecs[10] = '{8'd3,   8'd85,  8'd2};

    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.frac_val     = 8'd0;
    bus.multiplicand = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b product=%0d required 0/0/0", bus.busy, bus.done, bus.product);
    end
    rst = 1'b0;

    // Table vectors: hand-computed expectations, also cross-checked with the model.
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (model(vecs[i].f, vecs[i].m) !== vecs[i].exp) begin
        errors++;
        $display("FAIL table_model[%0d]: model %0d required %0d", i, model(vecs[i].f, vecs[i].m), vecs[i].exp);
      end
      run_op(vecs[i].f, vecs[i].m, 1'b0);
    end

    // Chained with the divider's Q1.7 fraction for j/21, multiplicand 21.
    for (int j = 0; j <= 21; j++) begin
      logic [7:0] fj;
      int         d;
      fj = 8'((j * 128) / 21);
      run_op(fj, 8'd21, 1'b0);
      d = int'(bus.product) - j;
      checks++;
      if (d > 1 || d < -1) begin
        errors++;
        $display("FAIL chain_j%0d: got %0d required %0d+-1", j, bus.product, j);
      end
    end

    // Operands and start toggled mid-run must not disturb the result.
    for (int k = 0; k < 4; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'b1);
    end

    // Back-to-back with start held high: new operands each accepted op.
    @(negedge clk);
    gap_check   = 1'b1;
    last_done_t = 0;
    for (int k = 0; k < 5; k++) begin
      int guard;
      logic [7:0] f;
      logic [7:0] m;
      guard = 0;
      while (bus.busy && guard < 30) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (guard >= 30) begin
        errors++;
        $display("FAIL b2b_timeout: busy stuck for %0d cycles required <30", guard);
      end
      f = 8'($urandom);
      m = 8'($urandom);
      bus.frac_val     = f;
      bus.multiplicand = m;
      bus.start        = 1'b1;
      sb.push_back(model(f, m));
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    gap_check = 1'b0;

    // Reset during RUN step 4 aborts without a done pulse.
    @(negedge clk);
    bus.frac_val     = 8'd100;
    bus.multiplicand = 8'd77;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b done=%0b product=%0d required 0/0/0", bus.busy, bus.done, bus.product);
    end
    repeat (15) @(negedge clk);
    run_op(8'd160, 8'd90, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
